storequeue_nway: RTL and testbench
==================================

Name: storequeue_nway

Overview:
- Parametrised successor store queue between dispatch, the store-writeback pipe, ROB commit and the dcache arbiter.
- Entries are allocated in program order at dispatch and filled at writeback by sqid rather than by robid CAM.
- Commit is by count, so up to COMMIT_WIDTH stores can commit per cycle; committed stores drain in order to dcache, and MMIO stores retire silently.
- Adds byte-granular store-to-load forwarding with youngest-older merge and a stall flag for unresolved older stores.

Parameters:
DEPTH, 16, entry count; power of two, >=4
DEPTH_LOG, 4, log2(DEPTH)
COMMIT_WIDTH, 2, max stores committed per cycle
ROBID_W, 7, robid width including wrap bit
ADDR_W, 64, store/load address width
DATA_W, 64, data width; byte mask width is DATA_W/8

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
enq_valid  in  1  dispatch allocates one store
enq_ready  out  1  queue can accept an allocation
enq_robid  in  ROBID_W  robid of the allocated store (debug/trace only)
enq_sqid  out  DEPTH_LOG+1  sqid assigned to the store, equal to tail
wb_valid  in  1  store address/data writeback
wb_sqid  in  DEPTH_LOG+1  target entry
wb_addr  in  ADDR_W  store address
wb_data  in  DATA_W  store data, byte-aligned within the dword
wb_bytemask  in  DATA_W/8  bytes written
wb_mmio  in  1  store targets MMIO
commit_cnt  in  $clog2(COMMIT_WIDTH+1)  number of oldest uncommitted stores committing
flush_valid  in  1  redirect
flush_sqid  in  DEPTH_LOG+1  first sqid squashed; tail rolls back to it
dc_req_valid  out  1  drain request to dcache arbiter
dc_req_ready  in  1  arbiter accepts
dc_req_addr  out  ADDR_W  head entry address
dc_req_data  out  DATA_W  head entry data
dc_req_mask  out  DATA_W/8  head entry byte mask
fwd_req_valid  in  1  load forwarding lookup
fwd_req_sqid  in  DEPTH_LOG+1  load's sqid; stores with sqid < this are older
fwd_req_addr  in  ADDR_W  load address
fwd_req_bytemask  in  DATA_W/8  bytes the load reads
fwd_resp_valid  out  1  response, one cycle after request
fwd_resp_data  out  DATA_W  forwarded bytes
fwd_resp_mask  out  DATA_W/8  bytes supplied by the queue
fwd_resp_stall  out  1  an older in-range store is not yet written back
count  out  DEPTH_LOG+1  occupied entries (tail - head)

Behaviour:
- Pointers:
  - head, cmt and tail are each DEPTH_LOG+1 bits with a wrap bit.
  - Invariant: head <= cmt <= tail in wrap order.
  - Empty when head == tail. Full when count == DEPTH.
- Per-entry state: valid, wbdone, mmio, committed, addr, data, mask.
- Reset (async, active-high):
  - head, cmt and tail go to 0; all valid/wbdone cleared.
  - Outputs: enq_ready=1, enq_sqid=0, count=0, dc_req_valid=0, fwd_resp_valid=0, fwd_resp_stall=0, fwd_resp_mask=0, fwd_resp_data=0.
  - Reset mid-drain or mid-forward discards everything.
- Enqueue:
  - enq_ready = (count < DEPTH) & ~flush_valid.
  - On fire, the entry at tail is set valid with wbdone=0, and tail increments.
  - There is no same-cycle bypass from dequeue: a full queue stays not-ready in the cycle it pops.
- Writeback:
  - On wb_valid, the entry at wb_sqid[DEPTH_LOG-1:0] latches addr/data/mask/mmio and sets wbdone, only if that entry is valid.
  - Writeback to an invalid entry, including one flushed in the same cycle, is ignored.
- Commit:
  - cmt += commit_cnt; the covered entries are marked committed.
  - Upstream guarantees cmt + commit_cnt <= tail and that every covered entry is wbdone.
  - The bench asserts both conditions.
- Drain:
  - The head entry is drainable when valid, committed and wbdone.
  - Non-MMIO: dc_req_valid=1, with payload driven combinationally from the head entry. Pop on dc_req_ready.
  - dc_req_valid and payload stay stable until accepted.
  - MMIO: the entry pops in one cycle with dc_req_valid=0.
  - At most one pop per cycle.
- Flush:
  - Entries in [flush_sqid, tail) are invalidated and tail := flush_sqid next cycle.
  - Committed entries are never in the flush range (assertion).
  - Same-cycle commit, drain and writeback to surviving entries all still apply.
- Forwarding:
  - Candidates are valid entries with sqid in [head, fwd_req_sqid), wrap-aware.
  - A candidate that is not wbdone sets stall=1. MMIO entries never forward.
  - For each byte b: take the youngest candidate with wbdone, addr[ADDR_W-1:3] == fwd_req_addr[ADDR_W-1:3], mask[b] and fwd_req_bytemask[b]. It supplies data byte b and sets fwd_resp_mask[b].
  - The result is registered, giving one-cycle latency from the request.
  - It reflects entry state sampled in the request cycle, before that cycle's writeback or flush updates.
  - Candidate ordering uses head-relative age, so a range crossing the wrap works.
  - fwd_req_sqid == head means an empty range: mask=0, stall=0.

Test Plan:
- Reset, then enqueue 16 stores with no drain -> enq_sqid 0..15; enq_ready=0 at count=16; 17th enq_valid is not accepted.
- Enq sqid 0, wb addr 0x1000, data 0x1122334455667788, mask 0xFF, commit_cnt=1 -> next cycle dc_req_valid=1, addr 0x1000. Hold ready=0 for 3 cycles -> payload stable; ready=1 -> count 1->0.
- Stores sq0 (mask 0x0F, data ..AA per byte) and sq1 (mask 0x03, data ..BB) at 0x2000, load sqid=2, addr 0x2000, bytemask 0xFF -> mask 0x0F; bytes 0-1 = BB, bytes 2-3 = AA; stall=0.
- sq0 not written back, load sqid=1 -> stall=1, mask=0. Same load with sqid=0 -> stall=0.
- 6 entries allocated, flush_sqid=3 with same-cycle enq_valid and wb to sqid 4 -> tail=3, count=3, enq ignored, entry 4 stays invalid.
- Wrap: drain 14 entries, enqueue across index 15->0, MMIO store at head with commit_cnt=2 -> MMIO entry pops with dc_req_valid=0; forwarding across the wrap still picks the youngest store.

Source files
------------

// File: rtl/storequeue_nway_if.sv
// Store queue port bundle: dispatch, writeback, commit,
// flush, dcache drain and load-forwarding lookup.
interface storequeue_nway_if #(
  parameter int DEPTH_LOG    = 4,
  parameter int COMMIT_WIDTH = 2,
  parameter int ROBID_W      = 7,
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64
);
  localparam int PW = DEPTH_LOG + 1;
  localparam int MW = DATA_W / 8;
  localparam int CW = $clog2(COMMIT_WIDTH + 1);

  logic              enq_valid;
  logic              enq_ready;
  logic [ROBID_W-1:0] enq_robid;
  logic [PW-1:0]     enq_sqid;

  logic              wb_valid;
  logic [PW-1:0]     wb_sqid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [MW-1:0]     wb_bytemask;
  logic              wb_mmio;

  logic [CW-1:0]     commit_cnt;

  logic              flush_valid;
  logic [PW-1:0]     flush_sqid;

  logic              dc_req_valid;
  logic              dc_req_ready;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_data;
  logic [MW-1:0]     dc_req_mask;

  logic              fwd_req_valid;
  logic [PW-1:0]     fwd_req_sqid;
  logic [ADDR_W-1:0] fwd_req_addr;
  logic [MW-1:0]     fwd_req_bytemask;
  logic              fwd_resp_valid;
  logic [DATA_W-1:0] fwd_resp_data;
  logic [MW-1:0]     fwd_resp_mask;
  logic              fwd_resp_stall;

  logic [PW-1:0]     count;

  modport master (
    output enq_valid, enq_robid,
    input  enq_ready, enq_sqid,
    output wb_valid, wb_sqid, wb_addr,
    output wb_data, wb_bytemask, wb_mmio,
    output commit_cnt,
    output flush_valid, flush_sqid,
    input  dc_req_valid, dc_req_addr,
    input  dc_req_data, dc_req_mask,
    output dc_req_ready,
    output fwd_req_valid, fwd_req_sqid,
    output fwd_req_addr, fwd_req_bytemask,
    input  fwd_resp_valid, fwd_resp_data,
    input  fwd_resp_mask, fwd_resp_stall,
    input  count
  );

  modport slave (
    input  enq_valid, enq_robid,
    output enq_ready, enq_sqid,
    input  wb_valid, wb_sqid, wb_addr,
    input  wb_data, wb_bytemask, wb_mmio,
    input  commit_cnt,
    input  flush_valid, flush_sqid,
    output dc_req_valid, dc_req_addr,
    output dc_req_data, dc_req_mask,
    input  dc_req_ready,
    input  fwd_req_valid, fwd_req_sqid,
    input  fwd_req_addr, fwd_req_bytemask,
    output fwd_resp_valid, fwd_resp_data,
    output fwd_resp_mask, fwd_resp_stall,
    output count
  );
endinterface

// File: rtl/storequeue_nway.sv
// In-order store queue: sqid-indexed writeback, count-based
// commit, in-order dcache drain, byte-merging load forwarding.
module storequeue_nway #(
  parameter int DEPTH        = 16,
  parameter int DEPTH_LOG    = 4,
  parameter int COMMIT_WIDTH = 2,
  parameter int ROBID_W      = 7,
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64
) (
  input logic clock,
  input logic reset,
  storequeue_nway_if.slave sq
);
  localparam int PW = DEPTH_LOG + 1;
  localparam int MW = DATA_W / 8;

  typedef logic [PW-1:0]        ptr_t;
  typedef logic [DEPTH_LOG-1:0] idx_t;

  ptr_t head, cmt, tail, cnt;
  idx_t hidx, cidx, tidx, widx;

  logic [DEPTH-1:0]  valid, wbdone, mmio, cmtd;
  logic [DEPTH-1:0]  kill, cset;
  logic [ADDR_W-1:0] addr [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [MW-1:0]     mask [DEPTH];

  logic enq_fire, drainable, pop, wb_hit;
  ptr_t flush_off, rng;

  logic [DATA_W-1:0] f_data, r_data;
  logic [MW-1:0]     f_mask, r_mask;
  logic              f_stall, r_stall, r_valid;
  logic              unused_bits;

  assign hidx = head[DEPTH_LOG-1:0];
  assign cidx = cmt[DEPTH_LOG-1:0];
  assign tidx = tail[DEPTH_LOG-1:0];
  assign widx = sq.wb_sqid[DEPTH_LOG-1:0];
  assign cnt  = tail - head;

  assign sq.count     = cnt;
  assign sq.enq_sqid  = tail;
  assign sq.enq_ready = (cnt < ptr_t'(DEPTH))
                      & ~sq.flush_valid;
  assign enq_fire = sq.enq_valid & sq.enq_ready;

  // MMIO heads retire without ever asking the dcache
  assign drainable = valid[hidx] & cmtd[hidx]
                   & wbdone[hidx];
  assign pop = drainable
             & (mmio[hidx] | sq.dc_req_ready);

  assign sq.dc_req_valid = drainable & ~mmio[hidx];
  assign sq.dc_req_addr  = addr[hidx];
  assign sq.dc_req_data  = data[hidx];
  assign sq.dc_req_mask  = mask[hidx];

  assign flush_off = sq.flush_sqid - head;
  assign rng       = sq.fwd_req_sqid - head;
  assign wb_hit    = sq.wb_valid & valid[widx]
                   & ~kill[widx];

  always_comb begin : flag_gen
    idx_t age, cage;
    age  = '0;
    cage = '0;
    kill = '0;
    cset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age  = idx_t'(i) - hidx;
      cage = idx_t'(i) - cidx;
      kill[i] = sq.flush_valid
              & (ptr_t'(age) >= flush_off)
              & (ptr_t'(age) < cnt);
      cset[i] = int'(cage) < int'(sq.commit_cnt);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head   <= '0;
      cmt    <= '0;
      tail   <= '0;
      valid  <= '0;
      wbdone <= '0;
      mmio   <= '0;
      cmtd   <= '0;
    end else begin
      head <= head + ptr_t'(pop);
      cmt  <= cmt + ptr_t'(sq.commit_cnt);
      tail <= sq.flush_valid ? sq.flush_sqid
            : tail + ptr_t'(enq_fire);
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i] || (pop && idx_t'(i) == hidx)) begin
          valid[i]  <= 1'b0;
          wbdone[i] <= 1'b0;
          cmtd[i]   <= 1'b0;
        end else if (enq_fire && idx_t'(i) == tidx) begin
          valid[i]  <= 1'b1;
          wbdone[i] <= 1'b0;
          cmtd[i]   <= 1'b0;
        end else begin
          if (cset[i]) cmtd[i] <= 1'b1;
          if (wb_hit && idx_t'(i) == widx) begin
            wbdone[i] <= 1'b1;
            mmio[i]   <= sq.wb_mmio;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wb_hit) begin
      addr[widx] <= sq.wb_addr;
      data[widx] <= sq.wb_data;
      mask[widx] <= sq.wb_bytemask;
    end
  end

  // Walk oldest to youngest so younger matches overwrite
  always_comb begin : fwd_gen
    idx_t j;
    j       = '0;
    f_data  = '0;
    f_mask  = '0;
    f_stall = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      j = hidx + idx_t'(k);
      if (valid[j] && (ptr_t'(k) < rng)) begin
        if (!wbdone[j]) begin
          f_stall = 1'b1;
        end else if (!mmio[j] &&
            addr[j][ADDR_W-1:3] ==
            sq.fwd_req_addr[ADDR_W-1:3]) begin
          for (int b = 0; b < MW; b++) begin
            if (mask[j][b] && sq.fwd_req_bytemask[b]) begin
              f_data[8*b +: 8] = data[j][8*b +: 8];
              f_mask[b]        = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mask  <= '0;
      r_stall <= 1'b0;
    end else begin
      r_valid <= sq.fwd_req_valid;
      r_data  <= sq.fwd_req_valid ? f_data : '0;
      r_mask  <= sq.fwd_req_valid ? f_mask : '0;
      r_stall <= sq.fwd_req_valid & f_stall;
    end
  end

  assign sq.fwd_resp_valid = r_valid;
  assign sq.fwd_resp_data  = r_data;
  assign sq.fwd_resp_mask  = r_mask;
  assign sq.fwd_resp_stall = r_stall;

  assign unused_bits = ^{sq.enq_robid,
                         sq.wb_sqid[DEPTH_LOG],
                         sq.fwd_req_addr[2:0]};
endmodule

// File: tb/tb_storequeue_nway.sv
// Directed plus random checks of storequeue_nway against
// a queue-of-stores reference model.
module tb_storequeue_nway;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  storequeue_nway_if sq_if ();
  storequeue_nway dut (
    .clock(clock),
    .reset(reset),
    .sq   (sq_if)
  );

  typedef struct {
    logic [4:0]  sqid;
    bit          wbd;
    bit          mmio;
    bit          cmtd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } ent_t;

  ent_t q[$];
  logic [4:0] mh;
  int tests = 0;
  int fails = 0;

  bit pv, nv, ps, ns;
  logic [63:0] pd, nd;
  logic [7:0] pm, nm;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic int ncmt();
    int c = 0;
    foreach (q[j]) if (q[j].cmtd) c++;
    return c;
  endfunction

  task automatic idle();
    sq_if.enq_valid        = 1'b0;
    sq_if.enq_robid        = '0;
    sq_if.wb_valid         = 1'b0;
    sq_if.wb_sqid          = '0;
    sq_if.wb_addr          = '0;
    sq_if.wb_data          = '0;
    sq_if.wb_bytemask      = '0;
    sq_if.wb_mmio          = 1'b0;
    sq_if.commit_cnt       = '0;
    sq_if.flush_valid      = 1'b0;
    sq_if.flush_sqid       = '0;
    sq_if.dc_req_ready     = 1'b0;
    sq_if.fwd_req_valid    = 1'b0;
    sq_if.fwd_req_sqid     = '0;
    sq_if.fwd_req_addr     = '0;
    sq_if.fwd_req_bytemask = '0;
  endtask

  // youngest older wbdone non-MMIO match supplies each byte
  task automatic fwd_model();
    int len;
    nv = sq_if.fwd_req_valid;
    nd = '0;
    nm = '0;
    ns = 1'b0;
    len = int'(5'(sq_if.fwd_req_sqid - mh));
    if (len > q.size()) len = q.size();
    for (int j = 0; j < len; j++)
      if (!q[j].wbd) ns = 1'b1;
    for (int b = 0; b < 8; b++)
      for (int j = len - 1; j >= 0; j--)
        if (!nm[b] && q[j].wbd && !q[j].mmio &&
            q[j].addr[63:3] == sq_if.fwd_req_addr[63:3] &&
            q[j].mask[b] && sq_if.fwd_req_bytemask[b]) begin
          nm[b] = 1'b1;
          nd[8*b +: 8] = q[j].data[8*b +: 8];
        end
    if (!nv) begin
      nd = '0;
      nm = '0;
      ns = 1'b0;
    end
  endtask

  task automatic model_step();
    int n, nc, cc, fpos;
    bit pop, fire, legal;
    logic [4:0] tl;
    ent_t e;
    n  = q.size();
    nc = ncmt();
    cc = int'(sq_if.commit_cnt);
    tl = mh + 5'(n);
    fire = sq_if.enq_valid && n < 16 && !sq_if.flush_valid;
    pop = n > 0 && q[0].cmtd && q[0].wbd &&
          (q[0].mmio || sq_if.dc_req_ready);
    fpos = sq_if.flush_valid
         ? int'(5'(sq_if.flush_sqid - mh)) : n;
    if (cc > 0) begin
      legal = (nc + cc <= n);
      for (int j = nc; j < nc + cc && j < n; j++)
        if (!q[j].wbd) legal = 1'b0;
      chk("commit_legal", 64'(legal), 64'd1);
      for (int j = nc; j < nc + cc && j < n; j++)
        q[j].cmtd = 1'b1;
    end
    if (sq_if.flush_valid)
      chk("flush_legal",
          64'(fpos >= nc + cc && fpos <= n), 64'd1);
    if (sq_if.wb_valid)
      for (int j = 0; j < n; j++)
        if (q[j].sqid[3:0] == sq_if.wb_sqid[3:0] &&
            j < fpos) begin
          q[j].wbd  = 1'b1;
          q[j].mmio = sq_if.wb_mmio;
          q[j].addr = sq_if.wb_addr;
          q[j].data = sq_if.wb_data;
          q[j].mask = sq_if.wb_bytemask;
        end
    while (q.size() > fpos) void'(q.pop_back());
    if (pop) begin
      void'(q.pop_front());
      mh = mh + 5'd1;
    end
    if (fire) begin
      e = '{tl, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0};
      q.push_back(e);
    end
  endtask

  task automatic cycle();
    bit dv;
    @(negedge clock);
    chk("count", 64'(sq_if.count), 64'(q.size()));
    chk("enq_ready", 64'(sq_if.enq_ready),
        64'(q.size() < 16 && !sq_if.flush_valid));
    chk("enq_sqid", 64'(sq_if.enq_sqid),
        64'(5'(mh + 5'(q.size()))));
    dv = q.size() > 0 && q[0].cmtd && q[0].wbd &&
         !q[0].mmio;
    chk("dc_valid", 64'(sq_if.dc_req_valid), 64'(dv));
    if (dv) begin
      chk("dc_addr", sq_if.dc_req_addr, q[0].addr);
      chk("dc_data", sq_if.dc_req_data, q[0].data);
      chk("dc_mask", 64'(sq_if.dc_req_mask),
          64'(q[0].mask));
    end
    chk("fwd_valid", 64'(sq_if.fwd_resp_valid), 64'(pv));
    if (pv) begin
      chk("fwd_data", sq_if.fwd_resp_data, pd);
      chk("fwd_mask", 64'(sq_if.fwd_resp_mask), 64'(pm));
      chk("fwd_stall", 64'(sq_if.fwd_resp_stall),
          64'(ps));
    end
    fwd_model();
    @(posedge clock);
    model_step();
    #1;
    pv = nv;
    pd = nd;
    pm = nm;
    ps = ns;
  endtask

  task automatic do_enq();
    idle();
    sq_if.enq_valid = 1'b1;
    sq_if.enq_robid = 7'($urandom);
    cycle();
  endtask

  task automatic do_wb(logic [4:0] s, logic [63:0] a,
                       logic [63:0] d, logic [7:0] m,
                       bit io);
    idle();
    sq_if.wb_valid    = 1'b1;
    sq_if.wb_sqid     = s;
    sq_if.wb_addr     = a;
    sq_if.wb_data     = d;
    sq_if.wb_bytemask = m;
    sq_if.wb_mmio     = io;
    cycle();
  endtask

  task automatic do_fwd(logic [4:0] s, logic [63:0] a,
                        logic [7:0] m);
    idle();
    sq_if.fwd_req_valid    = 1'b1;
    sq_if.fwd_req_sqid     = s;
    sq_if.fwd_req_addr     = a;
    sq_if.fwd_req_bytemask = m;
    cycle();
  endtask

  task automatic do_flush(logic [4:0] s);
    idle();
    sq_if.flush_valid = 1'b1;
    sq_if.flush_sqid  = s;
    cycle();
  endtask

  task automatic push_drain();
    logic [4:0] s;
    s = mh;
    do_enq();
    do_wb(s, 64'h100, 64'h0123_4567_89AB_CDEF,
          8'hFF, 1'b0);
    idle();
    sq_if.commit_cnt = 2'd1;
    cycle();
    idle();
    sq_if.dc_req_ready = 1'b1;
    cycle();
  endtask

  task automatic rand_step();
    int n, nc, k, cc, j;
    n  = q.size();
    nc = ncmt();
    idle();
    sq_if.enq_valid    = $urandom_range(0, 99) < 55;
    sq_if.enq_robid    = 7'($urandom);
    sq_if.dc_req_ready = $urandom_range(0, 1) == 1;
    k = 0;
    while (k < 2 && nc + k < n && q[nc + k].wbd) k++;
    cc = int'($urandom_range(0, k));
    sq_if.commit_cnt = 2'(cc);
    if (n > nc && $urandom_range(0, 2) != 0) begin
      j = int'($urandom_range(nc, n - 1));
      sq_if.wb_valid = 1'b1;
      sq_if.wb_sqid  = q[j].sqid;
    end else if (n < 16 && $urandom_range(0, 3) == 0) begin
      sq_if.wb_valid = 1'b1;
      sq_if.wb_sqid  = mh + 5'(n);
    end
    case ($urandom_range(0, 2))
      0:       sq_if.wb_addr = 64'h3000;
      1:       sq_if.wb_addr = 64'h3008;
      default: sq_if.wb_addr = 64'h3004;
    endcase
    sq_if.wb_data     = {$urandom, $urandom};
    sq_if.wb_bytemask = 8'($urandom_range(1, 255));
    sq_if.wb_mmio     = $urandom_range(0, 7) == 0;
    if ($urandom_range(0, 19) == 0) begin
      sq_if.flush_valid = 1'b1;
      sq_if.flush_sqid  =
        mh + 5'($urandom_range(nc + cc, n));
    end
    if ($urandom_range(0, 9) < 7) begin
      sq_if.fwd_req_valid    = 1'b1;
      sq_if.fwd_req_sqid     =
        mh + 5'($urandom_range(0, n));
      sq_if.fwd_req_addr     =
        $urandom_range(0, 1) == 1 ? 64'h3000 : 64'h3008;
      sq_if.fwd_req_bytemask = 8'($urandom);
    end
    cycle();
  endtask

  initial begin
    logic [4:0] b;
    idle();
    mh = '0;
    pv = 1'b0;
    #12;
    chk("rst_enq_ready", 64'(sq_if.enq_ready), 64'd1);
    chk("rst_enq_sqid", 64'(sq_if.enq_sqid), 64'd0);
    chk("rst_count", 64'(sq_if.count), 64'd0);
    chk("rst_dc_valid", 64'(sq_if.dc_req_valid), 64'd0);
    chk("rst_fwd_valid", 64'(sq_if.fwd_resp_valid), 64'd0);
    chk("rst_fwd_stall", 64'(sq_if.fwd_resp_stall), 64'd0);
    chk("rst_fwd_mask", 64'(sq_if.fwd_resp_mask), 64'd0);
    chk("rst_fwd_data", sq_if.fwd_resp_data, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      idle();
      sq_if.enq_valid = 1'b1;
      chk("fill_sqid", 64'(sq_if.enq_sqid), 64'(i));
      cycle();
    end
    chk("full_ready", 64'(sq_if.enq_ready), 64'd0);
    do_enq();
    chk("full_count", 64'(sq_if.count), 64'd16);
    do_flush(5'd0);
    chk("flush_all", 64'(sq_if.count), 64'd0);

    do_enq();
    do_wb(5'd0, 64'h1000, 64'h1122_3344_5566_7788,
          8'hFF, 1'b0);
    idle();
    sq_if.commit_cnt = 2'd1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk("drain_valid", 64'(sq_if.dc_req_valid), 64'd1);
      chk("drain_addr", sq_if.dc_req_addr, 64'h1000);
      chk("drain_data", sq_if.dc_req_data,
          64'h1122_3344_5566_7788);
      idle();
      cycle();
    end
    chk("drain_count1", 64'(sq_if.count), 64'd1);
    idle();
    sq_if.dc_req_ready = 1'b1;
    cycle();
    chk("drain_count0", 64'(sq_if.count), 64'd0);

    b = mh;
    do_enq();
    do_enq();
    do_wb(b, 64'h2000, 64'hAAAA_AAAA_AAAA_AAAA,
          8'h0F, 1'b0);
    do_wb(b + 5'd1, 64'h2000, 64'hBBBB_BBBB_BBBB_BBBB,
          8'h03, 1'b0);
    do_fwd(b + 5'd2, 64'h2000, 8'hFF);
    chk("merge_mask", 64'(sq_if.fwd_resp_mask), 64'h0F);
    chk("merge_data", sq_if.fwd_resp_data,
        64'h0000_0000_AAAA_BBBB);
    chk("merge_stall", 64'(sq_if.fwd_resp_stall), 64'd0);
    do_enq();
    do_fwd(b + 5'd3, 64'h5000, 8'hFF);
    chk("stall_set", 64'(sq_if.fwd_resp_stall), 64'd1);
    chk("stall_mask", 64'(sq_if.fwd_resp_mask), 64'd0);
    do_fwd(b + 5'd2, 64'h5000, 8'hFF);
    chk("stall_clr", 64'(sq_if.fwd_resp_stall), 64'd0);
    do_fwd(b, 64'h2000, 8'hFF);
    chk("empty_mask", 64'(sq_if.fwd_resp_mask), 64'd0);
    chk("empty_stall", 64'(sq_if.fwd_resp_stall), 64'd0);
    do_flush(b);

    b = mh;
    for (int i = 0; i < 6; i++) do_enq();
    idle();
    sq_if.flush_valid = 1'b1;
    sq_if.flush_sqid  = b + 5'd3;
    sq_if.enq_valid   = 1'b1;
    sq_if.wb_valid    = 1'b1;
    sq_if.wb_sqid     = b + 5'd4;
    sq_if.wb_addr     = 64'h2000;
    sq_if.wb_data     = 64'hCCCC_CCCC_CCCC_CCCC;
    sq_if.wb_bytemask = 8'hFF;
    cycle();
    chk("flush_count", 64'(sq_if.count), 64'd3);
    chk("flush_tail", 64'(sq_if.enq_sqid),
        64'(5'(b + 5'd3)));
    do_flush(b);

    while (mh[3:0] != 4'd14) push_drain();
    b = mh;
    for (int i = 0; i < 4; i++) do_enq();
    do_wb(b, 64'h4000, 64'h9999_9999_9999_9999,
          8'hFF, 1'b1);
    do_wb(b + 5'd1, 64'h4000, 64'h1111_1111_1111_1111,
          8'hFF, 1'b0);
    do_wb(b + 5'd2, 64'h4000, 64'h2222_2222_2222_2222,
          8'h0F, 1'b0);
    do_fwd(b + 5'd3, 64'h4000, 8'hFF);
    chk("wrap_mask", 64'(sq_if.fwd_resp_mask), 64'hFF);
    chk("wrap_data", sq_if.fwd_resp_data,
        64'h1111_1111_2222_2222);
    chk("wrap_stall", 64'(sq_if.fwd_resp_stall), 64'd0);
    idle();
    sq_if.commit_cnt = 2'd2;
    cycle();
    chk("mmio_dcv", 64'(sq_if.dc_req_valid), 64'd0);
    chk("mmio_cnt4", 64'(sq_if.count), 64'd4);
    idle();
    cycle();
    chk("mmio_cnt3", 64'(sq_if.count), 64'd3);
    chk("post_mmio_dcv", 64'(sq_if.dc_req_valid), 64'd1);
    chk("post_mmio_addr", sq_if.dc_req_addr, 64'h4000);
    idle();
    sq_if.dc_req_ready = 1'b1;
    cycle();
    chk("wrap_cnt2", 64'(sq_if.count), 64'd2);

    for (int i = 0; i < 3000; i++) rand_step();

    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_count", 64'(sq_if.count), 64'd0);
    chk("midrst_dcv", 64'(sq_if.dc_req_valid), 64'd0);
    chk("midrst_fwdv", 64'(sq_if.fwd_resp_valid), 64'd0);
    chk("midrst_ready", 64'(sq_if.enq_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
